// File: rtl/filtro_vagas_if.sv
// Signal bundle between the vacancy sensors, the conditioning stage and the selector/status logic.
interface filtro_vagas_if;
  logic [7:0] Sensor;
  logic [7:0] CH;
  logic       Varredura;
  logic [3:0] Livres;
  logic       Lotado;
  logic       Mudou;

  modport master (output Sensor, input CH, Varredura, Livres, Lotado, Mudou);
  modport slave  (input Sensor, output CH, Varredura, Livres, Lotado, Mudou);
endinterface

// File: rtl/filtro_vagas.sv
// Vacancy input conditioning: 2-flop sync + per-bit debounce, free-space count,
// full flag, change pulse and the selector's column-scan phase.
module filtro_vagas_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic s2,
  output logic ch,
  output logic upd
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // High on the edge where this bit accepts its new value.
  assign upd = (s2 != ch) && (cnt == LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
      ch  <= 1'b0;
    end else if (s2 == ch) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      ch  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module filtro_vagas #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  filtro_vagas_if.slave  bus
);
  localparam int NUM_LANES = 8;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [NUM_LANES-1:0] s1, s2, ch, upd;
  logic [3:0]           free, livres;
  logic                 lotado, mudou, varredura;
  logic [DW-1:0]        div;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      filtro_vagas_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
        .Clock (Clock),
        .Reset (Reset),
        .s2    (s2[i]),
        .ch    (ch[i]),
        .upd   (upd[i])
      );
    end
  endgenerate

  always_comb begin
    free = 4'd8;
    for (int j = 0; j < NUM_LANES; j++) free = free - {3'b000, ch[j]};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1     <= '0;
      s2     <= '0;
      mudou  <= 1'b0;
      livres <= 4'd8;
      lotado <= 1'b0;
    end else begin
      s1     <= bus.Sensor;
      s2     <= s1;
      mudou  <= |upd;
      livres <= free;
      lotado <= (free == 4'd0);
    end
  end

  // Free-running scan phase, independent of sensor activity.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div       <= '0;
      varredura <= 1'b0;
    end else if (div == DIV_LAST) begin
      div       <= '0;
      varredura <= ~varredura;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign bus.CH        = ch;
  assign bus.Mudou     = mudou;
  assign bus.Livres    = livres;
  assign bus.Lotado    = lotado;
  assign bus.Varredura = varredura;
endmodule

// File: tb/tb_filtro_vagas.sv
// Directed table-driven bench for filtro_vagas with DEBOUNCE_CYCLES=4, SCAN_DIV=2.
module tb_filtro_vagas;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  filtro_vagas_if bus();

  filtro_vagas #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic [7:0] sensor;
    logic [7:0] ch;
    logic       mudou;
    logic [3:0] livres;
    logic       lotado;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic rst, input logic [7:0] sensor,
                     input logic [7:0] ch, input logic mudou,
                     input logic [3:0] livres, input logic lotado);
    vec_t v;
    v.rst = rst; v.sensor = sensor; v.ch = ch;
    v.mudou = mudou; v.livres = livres; v.lotado = lotado;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic [7:0] sensor);
    @(negedge Clock);
    Reset      = rst;
    bus.Sensor = sensor;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    bus.Sensor = 8'hFF;

    // row j is the state expected just after edge j
    add(3, 1'b1, 8'hFF, 8'h00, 1'b0, 4'd8, 1'b0);  // reset with all sensors high
    add(1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd8, 1'b0);
    add(5, 1'b0, 8'h08, 8'h00, 1'b0, 4'd8, 1'b0);  // bit 3 captured at edge 4
    add(1, 1'b0, 8'h08, 8'h08, 1'b1, 4'd8, 1'b0);  // accepted at edge 9
    add(2, 1'b0, 8'h08, 8'h08, 1'b0, 4'd7, 1'b0);
    add(3, 1'b0, 8'h09, 8'h08, 1'b0, 4'd7, 1'b0);  // 3-cycle glitch on bit 0
    add(5, 1'b0, 8'h08, 8'h08, 1'b0, 4'd7, 1'b0);
    add(4, 1'b0, 8'h09, 8'h08, 1'b0, 4'd7, 1'b0);  // 4-cycle pulse, captured at 20
    add(1, 1'b0, 8'h08, 8'h08, 1'b0, 4'd7, 1'b0);
    add(1, 1'b0, 8'h08, 8'h09, 1'b1, 4'd7, 1'b0);  // edge 25
    add(3, 1'b0, 8'h08, 8'h09, 1'b0, 4'd6, 1'b0);
    add(1, 1'b0, 8'h08, 8'h08, 1'b1, 4'd6, 1'b0);  // falls back at edge 29
    add(2, 1'b0, 8'h08, 8'h08, 1'b0, 4'd7, 1'b0);
    add(5, 1'b0, 8'hFF, 8'h08, 1'b0, 4'd7, 1'b0);  // all high, captured at 32
    add(1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd7, 1'b0);  // edge 37
    add(2, 1'b0, 8'hFF, 8'hFF, 1'b0, 4'd0, 1'b1);
    add(5, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd0, 1'b1);  // all low, captured at 40
    add(1, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0, 1'b1);  // edge 45
    add(2, 1'b0, 8'h00, 8'h00, 1'b0, 4'd8, 1'b0);

    for (int j = 0; j < tbl.size(); j++) begin
      cyc(tbl[j].rst, tbl[j].sensor);
      check("CH",     j, bus.CH,                tbl[j].ch);
      check("Mudou",  j, {7'd0, bus.Mudou},     {7'd0, tbl[j].mudou});
      check("Livres", j, {4'd0, bus.Livres},    {4'd0, tbl[j].livres});
      check("Lotado", j, {7'd0, bus.Lotado},    {7'd0, tbl[j].lotado});
      if (tbl[j].rst) check("Varredura_rst", j, {7'd0, bus.Varredura}, 8'h00);
    end

    // Reset at edge k+3 during a bit-5 debounce; held value recaptured at k+5.
    for (int m = 0; m < 3; m++) begin
      cyc(1'b0, 8'h20);
      check("midrst_CH", m, bus.CH, 8'h00);
    end
    for (int m = 3; m < 5; m++) begin
      cyc(1'b1, 8'h20);
      check("midrst_CH", m, bus.CH, 8'h00);
      check("midrst_Livres", m, {4'd0, bus.Livres}, 8'd8);
    end
    for (int m = 5; m < 10; m++) begin
      cyc(1'b0, 8'h20);
      check("midrst_CH", m, bus.CH, 8'h00);
      check("midrst_Mudou", m, {7'd0, bus.Mudou}, 8'h00);
    end
    cyc(1'b0, 8'h20);
    check("midrst_CH", 10, bus.CH, 8'h20);
    check("midrst_Mudou", 10, {7'd0, bus.Mudou}, 8'h01);
    cyc(1'b0, 8'h20);
    check("midrst_Livres", 11, {4'd0, bus.Livres}, 8'd7);
    check("midrst_Mudou", 11, {7'd0, bus.Mudou}, 8'h00);

    // Scan: toggles every 2 edges from release, first rise at r+1, sensors churning.
    cyc(1'b1, 8'h00);
    check("scan_rst", 0, {7'd0, bus.Varredura}, 8'h00);
    for (int m = 0; m < 12; m++) begin
      logic [7:0] want;
      cyc(1'b0, 8'($urandom_range(0, 255)));
      want = ((m == 1) || (m == 2) || (m == 5) || (m == 6) || (m == 9) || (m == 10))
             ? 8'h01 : 8'h00;
      check("Varredura", m, {7'd0, bus.Varredura}, want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/filtro_vagas.md
# filtro_vagas

Input-conditioning stage for the parking-vacancy display. It takes the eight raw vacancy sensors/switches, synchronizes and debounces each one, and registers the result as the stable occupancy vector `CH[7:0]` consumed by the vacancy-selector/matrix driver. It also produces the column-scan phase signal that drives that selector's `Clock` input, plus a free-space count, a full flag and a change pulse for the status logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a bit is accepted. Legal range is ≥1 and ≤65535. Use 4 in simulation and 50000 on the board.
- `SCAN_DIV`, default 2: clock cycles per scan half-period. Legal range is ≥1.

Ports:
- `Clock`, in, 1: the single system clock. All logic is on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Sensor`, in, 8: raw asynchronous vacancy inputs. 1 means occupied. Bit i maps to `CH[i]`.
- `CH`, out, 8: debounced occupancy. 1 means occupied.
- `Varredura`, out, 1: scan phase, square wave. It connects to the selector's `Clock` input.
- `Livres`, out, 4: number of 0 bits in `CH` (range 0..8).
- `Lotado`, out, 1: high when `Livres` == 0.
- `Mudou`, out, 1: one-cycle pulse when `CH` changes value.

## Operation
- **Synchronizer, per bit:** `s1 <= Sensor`, then `s2 <= s1`. Only `s2` is used downstream.
- **Debouncer, per bit i:** one counter `cnt[i]`, sized for `DEBOUNCE_CYCLES-1`.
  - If `s2[i] == CH[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `CH[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- The eight bits are fully independent. Several bits may update on the same edge.
- **Change pulse:** `Mudou` is registered high on the edge where any `CH` bit updates, and low otherwise. Simultaneous bit changes produce a single one-cycle pulse.
- **Counter outputs:**
  - `Livres` is registered as 8 minus popcount(`CH`), computed from the current `CH` register.
  - `Lotado` is registered as (8 minus popcount(`CH`)) == 0, on the same edge as `Livres`.
  - Both therefore lag `CH` by one cycle.
- **Scan generator:**
  - `div` counts 0..`SCAN_DIV`-1 and wraps.
  - On the wrap edge, `Varredura <= ~Varredura`.
  - The period is 2·`SCAN_DIV` cycles with a 50% duty cycle. It runs regardless of sensor activity.
- **Reset behaviour:** while `Reset` is high on an edge, the block sets the following values.
  - `s1`, `s2`, `CH`, every `cnt`, `div` and `Varredura` go to 0.
  - `Livres` goes to 8. `Lotado` and `Mudou` go to 0.
  - Reset overrides any in-progress debounce. Partial counts are discarded.

## Timing
- **Accept latency:** a `Sensor` bit changes and is held stable, first captured into `s1` at edge k. `CH` takes the new value at edge k+`DEBOUNCE_CYCLES`+1, the same edge `Mudou` rises. `Livres` and `Lotado` update at edge k+`DEBOUNCE_CYCLES`+2.
- **Glitch rejection:** any pulse at `s2` shorter than `DEBOUNCE_CYCLES` cycles clears `cnt` and leaves `CH` unchanged. In that case no `Mudou` pulse is produced.
- **Bounce:** when the input returns to the `CH` value mid-count, `cnt` clears and the full count restarts on the next deviation.
- **Scan after reset:** with `Reset` released before edge r, `Varredura` first rises at edge r+`SCAN_DIV`-1.
- **Sensor held during reset:** `CH` stays 0 during reset. After release it follows the normal accept latency, counted from the first edge `s1` captures after release.
- **Count limits:** `Livres` saturation cannot occur (range 0..8). `cnt` wraps only through the explicit clear, never by overflow.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SCAN_DIV`=2.
- **Reset values:** hold `Reset` for 3 cycles with `Sensor`=8'hFF → `CH`=0, `Livres`=8, `Lotado`=0, `Mudou`=0, `Varredura`=0 throughout reset.
- **Single accept:** `Sensor[3]` goes 0→1, first sampled at edge k → `CH`=8'h08 and `Mudou`=1 at edge k+5 only. `Livres`=7 at edge k+6.
- **Glitch rejection:** pulse `Sensor[0]` high for 3 cycles, then low → `CH` stays 0 and `Mudou` never asserts. A 4-cycle pulse → `CH[0]` goes to 1.
- **Simultaneous update and full flag:** `Sensor` goes 0→8'hFF in one cycle → all bits update on the same edge with one `Mudou` pulse. `Livres`=0 and `Lotado`=1 one cycle later. Returning to 8'h00 → `Livres`=8 and `Lotado`=0.
- **Scan waveform:** with `Reset` released, `Varredura` toggles every 2 edges → period 4, first rise at edge r+1, unaffected by `Sensor` activity.
- **Reset mid-operation:** assert `Reset` at edge k+3 during a debounce of `Sensor[5]` → `CH` stays 0. After release, `CH[5]` updates exactly 5 edges after `s1` recaptures the held value.
